// File: rtl/tcp_pkg.sv
// tcp_pkg: TCP header constants, parser state encoding and the segment descriptor shared with tcp_server
package tcp_pkg;

    localparam int TCP_HDR_MIN_LEN = 20;

    localparam int FIN = 0;
    localparam int SYN = 1;
    localparam int RST = 2;
    localparam int PSH = 3;
    localparam int ACK = 4;
    localparam int URG = 5;
    localparam int ECE = 6;
    localparam int CWR = 7;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_OPT,
        ST_PAY,
        ST_ERRD,
        ST_DROP,
        ST_DESC
    } rx_state_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
        logic [15:0] window;
        logic [15:0] pl_len;
        logic        err;
    } tcp_seg_desc_t;

endpackage

// File: rtl/tcp_rx_parser.sv
// tcp_rx_parser: splits one TCP segment per packet into a header descriptor and a zero-latency payload stream
module tcp_rx_parser
    import tcp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'd80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_pl_data,
    output logic        m_pl_valid,
    output logic        m_pl_last,
    input  logic        m_pl_ready,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [15:0] desc_src_port,
    output logic [15:0] desc_dst_port,
    output logic [31:0] desc_seq,
    output logic [31:0] desc_ack,
    output logic [7:0]  desc_flags,
    output logic [15:0] desc_window,
    output logic [15:0] desc_pl_len,
    output logic        desc_err
);

    localparam logic [5:0] LAST_HDR = 6'(TCP_HDR_MIN_LEN - 1);

    rx_state_t     state, state_n;
    tcp_seg_desc_t d;
    logic [3:0]    doff;
    logic [5:0]    cnt;
    logic [5:0]    opt_end;
    logic          beat;
    logic          restart;

    assign beat    = s_valid && s_ready;
    assign opt_end = {doff, 2'b00} - 6'd1;
    // Any return to HDR starts a fresh segment, so the capture registers are wiped there
    assign restart = state_n == ST_HDR && (state != ST_HDR || (beat && s_last));

    assign s_ready    = !rst && (state == ST_PAY ? m_pl_ready : state != ST_DESC);
    assign m_pl_data  = s_data;
    assign m_pl_valid = !rst && state == ST_PAY && s_valid;
    assign m_pl_last  = m_pl_valid && s_last;

    assign desc_valid    = state == ST_DESC;
    assign desc_src_port = d.src_port;
    assign desc_dst_port = d.dst_port;
    assign desc_seq      = d.seq;
    assign desc_ack      = d.ack;
    assign desc_flags    = d.flags;
    assign desc_window   = d.window;
    assign desc_pl_len   = d.pl_len;
    assign desc_err      = d.err;

    always_comb begin
        state_n = state;
        case (state)
            ST_HDR:
                if (beat && cnt == LAST_HDR)
                    state_n = doff < 4'd5                ? (s_last ? ST_DESC : ST_ERRD)
                            : d.dst_port != LOCAL_PORT   ? (s_last ? ST_HDR : ST_DROP)
                            : s_last                     ? ST_DESC
                            : doff > 4'd5                ? ST_OPT : ST_PAY;
                else if (beat && s_last)
                    state_n = ST_DESC;
            ST_OPT:
                if (beat) state_n = s_last ? ST_DESC : cnt == opt_end ? ST_PAY : ST_OPT;
            ST_PAY, ST_ERRD:
                if (beat && s_last) state_n = ST_DESC;
            ST_DROP:
                if (beat && s_last) state_n = ST_HDR;
            ST_DESC:
                if (desc_ready) state_n = ST_HDR;
            default:
                state_n = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst ? ST_HDR : state_n;
        if (rst || restart) begin
            d    <= '0;
            doff <= '0;
            cnt  <= '0;
        end else if (beat) begin
            if (state == ST_HDR || state == ST_OPT) cnt <= cnt + 6'd1;
            if (state == ST_HDR) begin
                case (cnt)
                    6'd0:    d.src_port[15:8] <= s_data;
                    6'd1:    d.src_port[7:0]  <= s_data;
                    6'd2:    d.dst_port[15:8] <= s_data;
                    6'd3:    d.dst_port[7:0]  <= s_data;
                    6'd4:    d.seq[31:24]     <= s_data;
                    6'd5:    d.seq[23:16]     <= s_data;
                    6'd6:    d.seq[15:8]      <= s_data;
                    6'd7:    d.seq[7:0]       <= s_data;
                    6'd8:    d.ack[31:24]     <= s_data;
                    6'd9:    d.ack[23:16]     <= s_data;
                    6'd10:   d.ack[15:8]      <= s_data;
                    6'd11:   d.ack[7:0]       <= s_data;
                    6'd12:   doff             <= s_data[7:4];
                    6'd13:   d.flags          <= s_data;
                    6'd14:   d.window[15:8]   <= s_data;
                    6'd15:   d.window[7:0]    <= s_data;
                    default: ;
                endcase
                // Runt, bad offset, or a header that ends before its options
                if (s_last ? (cnt != LAST_HDR || doff != 4'd5) : (cnt == LAST_HDR && doff < 4'd5))
                    d.err <= 1'b1;
            end
            if (state == ST_OPT && s_last && cnt != opt_end) d.err <= 1'b1;
            if (state == ST_PAY && d.pl_len != 16'hFFFF) d.pl_len <= d.pl_len + 16'd1;
        end
    end

endmodule

// File: tb/tb_tcp_rx_parser.sv
// tb_tcp_rx_parser: table-driven and randomized checks of tcp_rx_parser against a segment-level model
module tb_tcp_rx_parser;
    import tcp_pkg::*;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       name;
        logic [15:0] dst;
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [3:0]  doff;
        int          len;
        int          pl_mode;
        bit          has;
        bit          err;
        logic [15:0] pl_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_pl_data;
    logic        m_pl_valid;
    logic        m_pl_last;
    logic        m_pl_ready = 1'b1;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    logic [15:0] desc_src_port, desc_dst_port, desc_window, desc_pl_len;
    logic [31:0] desc_seq, desc_ack;
    logic [7:0]  desc_flags;
    logic        desc_err;

    tcp_seg_desc_t dv;
    tcp_seg_desc_t got_desc[$];
    logic [8:0]    got_pl[$];
    bit            m_has;
    tcp_seg_desc_t m_desc;
    logic [8:0]    m_pl[$];
    int            pl_mode = 0;
    int            gap_pct = 0;
    int            checks = 0;
    int            passed = 0;

    tcp_rx_parser dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_pl_data(m_pl_data), .m_pl_valid(m_pl_valid), .m_pl_last(m_pl_last), .m_pl_ready(m_pl_ready),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src_port(desc_src_port), .desc_dst_port(desc_dst_port),
        .desc_seq(desc_seq), .desc_ack(desc_ack), .desc_flags(desc_flags),
        .desc_window(desc_window), .desc_pl_len(desc_pl_len), .desc_err(desc_err)
    );

    always #5 clk = ~clk;

    assign dv = {desc_src_port, desc_dst_port, desc_seq, desc_ack, desc_flags, desc_window, desc_pl_len, desc_err};

    always @(posedge clk) begin
        #1;
        m_pl_ready = pl_mode == 0 ? 1'b1 : pl_mode == 1 ? !m_pl_ready : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (desc_valid && desc_ready) got_desc.push_back(dv);
        if (m_pl_valid && m_pl_ready) got_pl.push_back({m_pl_last, m_pl_data});
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bq_t build(input logic [15:0] dst, input logic [31:0] seq, input logic [7:0] flags,
                                  input logic [3:0] doff, input int len);
        bq_t b;
        int hl = 4 * int'(doff);
        logic [159:0] h = {16'h1234, dst, seq, 32'hCAFEBABE, doff, 4'h0, flags, 16'h4000, 16'hBEEF, 16'h0000};
        for (int i = 0; i < len; i++)
            b.push_back(i < 20 ? h[159 - 8*i -: 8] : i < hl ? 8'h01 : 8'(32'hA0 + i - hl));
        return b;
    endfunction

    // Segment-level reference: what tcp_server should see for a complete byte sequence
    function automatic void model(input bq_t b);
        logic [7:0] h[20];
        int n = b.size();
        int hl;
        m_pl.delete();
        m_desc = '0;
        m_has  = 1'b1;
        for (int i = 0; i < 20; i++) h[i] = i < n ? b[i] : 8'h00;
        m_desc.src_port = {h[0], h[1]};
        m_desc.dst_port = {h[2], h[3]};
        m_desc.seq      = {h[4], h[5], h[6], h[7]};
        m_desc.ack      = {h[8], h[9], h[10], h[11]};
        m_desc.flags    = h[13];
        m_desc.window   = {h[14], h[15]};
        hl = 4 * int'(h[12][7:4]);
        if (n < 20 || hl < 20) m_desc.err = 1'b1;
        else if (m_desc.dst_port != 16'd80) m_has = 1'b0;
        else if (n < hl) m_desc.err = 1'b1;
        else begin
            for (int i = hl; i < n; i++) m_pl.push_back({i == n - 1, b[i]});
            m_desc.pl_len = 16'(n - hl > 65535 ? 65535 : n - hl);
        end
    endfunction

    task automatic send(input bq_t b, input bit with_last);
        for (int i = 0; i < b.size(); i++) begin
            bit done = 0;
            int t = 0;
            while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = b[i];
            s_last  = with_last && i == b.size() - 1;
            while (!done) begin
                @(negedge clk);
                done = s_ready;
                @(posedge clk); #1;
                t++;
                if (!done && t > 1000) begin
                    chk("send_timeout", 1'b1, 1'b0);
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_check(input string name);
        int bad = 0;
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_ndesc"}, got_desc.size(), m_has);
        if (m_has && got_desc.size() == 1) chk({name, "_desc"}, got_desc[0], m_desc);
        chk({name, "_npl"}, got_pl.size(), m_pl.size());
        for (int i = 0; i < got_pl.size() && i < m_pl.size(); i++) if (got_pl[i] !== m_pl[i]) bad++;
        chk({name, "_pl"}, bad, 0);
    endtask

    task automatic run_seg(input string name, input bq_t b);
        got_desc.delete();
        got_pl.delete();
        model(b);
        send(b, 1'b1);
        finish_check(name);
    endtask

    initial begin
        vec_t vt[8];
        bq_t  b, b2;
        int   bad;
        vt[0] = '{"syn",       16'd80,     8'h02, 32'h11223344, 4'd5,  20, 0, 1, 0, 16'd0};
        vt[1] = '{"ackpsh",    16'd80,     8'h18, 32'h00001000, 4'd8,  37, 1, 1, 0, 16'd5};
        vt[2] = '{"badport",   16'h0017,   8'h10, 32'h00000055, 4'd5,  25, 0, 0, 0, 16'd0};
        vt[3] = '{"afterdrop", 16'd80,     8'h10, 32'h00002000, 4'd5,  23, 2, 1, 0, 16'd3};
        vt[4] = '{"runt",      16'd80,     8'h10, 32'hDEAD0001, 4'd5,  11, 0, 1, 1, 16'd0};
        vt[5] = '{"doff3",     16'd80,     8'h10, 32'hDEAD0002, 4'd3,  26, 0, 1, 1, 16'd0};
        vt[6] = '{"opttrunc",  16'd80,     8'h10, 32'hDEAD0003, 4'd6,  22, 0, 1, 1, 16'd0};
        vt[7] = '{"doff15",    16'd80,     8'h11, 32'h7F000001, 4'd15, 63, 2, 1, 0, 16'd3};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_desc_valid", desc_valid, 1'b0);
        chk("rst_pl_valid", m_pl_valid, 1'b0);
        chk("rst_pl_last", m_pl_last, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 1'b1);
        chk("idle_desc", dv, '0);
        @(posedge clk); #1;

        foreach (vt[k]) begin
            pl_mode = vt[k].pl_mode;
            run_seg(vt[k].name, build(vt[k].dst, vt[k].seq, vt[k].flags, vt[k].doff, vt[k].len));
            chk({vt[k].name, "_has"}, got_desc.size(), vt[k].has);
            if (vt[k].has && got_desc.size() == 1) begin
                chk({vt[k].name, "_err"}, got_desc[0].err, vt[k].err);
                chk({vt[k].name, "_pl_len"}, got_desc[0].pl_len, vt[k].pl_len);
                chk({vt[k].name, "_seq"}, got_desc[0].seq, vt[k].seq);
                if (!vt[k].err) chk({vt[k].name, "_flags"}, got_desc[0].flags, vt[k].flags);
            end
        end

        pl_mode    = 0;
        desc_ready = 1'b0;
        b = build(16'd80, 32'h55667788, 8'h12, 4'd5, 20);
        got_desc.delete();
        got_pl.delete();
        model(b);
        send(b, 1'b1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!desc_valid || s_ready || dv !== m_desc) bad++;
        end
        chk("hold_stable", bad, 0);
        b2 = build(16'd80, 32'h99AABBCC, 8'h11, 4'd5, 24);
        @(posedge clk); #1;
        desc_ready = 1'b1;
        s_valid    = 1'b1;
        s_data     = b2[0];
        s_last     = 1'b0;
        @(negedge clk);
        chk("hs_s_ready", s_ready, 1'b0);
        chk("hs_desc", desc_valid ? dv : '0, m_desc);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        got_desc.delete();
        got_pl.delete();
        model(b2);
        send(b2[1:$], 1'b1);
        finish_check("b2b");

        b = build(16'd80, 32'h01020304, 8'h18, 4'd5, 30);
        got_desc.delete();
        got_pl.delete();
        send(b[0:21], 1'b0);
        s_valid = 1'b1;
        s_data  = b[22];
        rst     = 1'b1;
        @(negedge clk);
        chk("rstpay_pl_valid", m_pl_valid, 1'b0);
        chk("rstpay_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rstpay_desc_valid", desc_valid, 1'b0);
        chk("rstpay_desc", dv, '0);
        chk("rstpay_s_ready", s_ready, 1'b1);
        chk("rstpay_nodesc", got_desc.size(), 0);
        chk("rstpay_npl", got_pl.size(), 2);
        @(posedge clk); #1;
        run_seg("after_rst", build(16'd80, 32'hABCDEF01, 8'h18, 4'd7, 34));

        pl_mode = 2;
        gap_pct = 20;
        for (int r = 0; r < 40; r++) begin
            int kind = $urandom_range(0, 9);
            logic [3:0] doff;
            int len, hl;
            logic [15:0] dst = 16'd80;
            if (kind < 2) begin
                doff = 4'($urandom);
                len  = $urandom_range(1, 19);
                dst  = 16'($urandom);
            end else if (kind == 2) begin
                doff = 4'($urandom_range(5, 8));
                len  = 4 * int'(doff) + $urandom_range(0, 6);
                dst  = 16'($urandom_range(81, 65535));
            end else if (kind == 3) begin
                doff = 4'($urandom_range(0, 4));
                len  = $urandom_range(20, 24);
            end else begin
                doff = 4'($urandom_range(5, 8));
                len  = 4 * int'(doff) + (doff == 4'd5 ? $urandom_range(0, 8) : $urandom_range(1, 8));
            end
            b  = build(dst, $urandom, 8'($urandom), doff, len);
            hl = 4 * int'(doff);
            for (int i = 20; i < len; i++) if (i >= hl) b[i] = 8'($urandom);
            run_seg($sformatf("rand%0d", r), b);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tcp_rx_parser.md
# tcp_rx_parser

Receive-side TCP segment parser sitting directly upstream of `tcp_server`. It accepts a byte stream of one TCP segment per packet, extracts the fixed 20-byte header, skips any options and forwards payload bytes. After the segment ends it presents one segment descriptor that `tcp_server` consumes to drive its connection state machine. Segments not addressed to `LOCAL_PORT` are dropped silently.

## Interface
- `LOCAL_PORT`, 16'd80: destination port accepted; all others are dropped.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_data` in 8: segment byte; network (big-endian) order.
- `s_valid` in 1: `s_data` valid.
- `s_last` in 1: final byte of the segment.
- `s_ready` out 1: parser accepts the byte.
- `m_pl_data` out 8: payload byte.
- `m_pl_valid` out 1: payload byte valid.
- `m_pl_last` out 1: final payload byte.
- `m_pl_ready` in 1: downstream accepts the payload byte.
- `desc_valid` out 1: descriptor valid.
- `desc_ready` in 1: descriptor consumed.
- `desc_src_port`, `desc_dst_port` out 16 each: ports.
- `desc_seq`, `desc_ack` out 32 each: sequence and acknowledgement numbers.
- `desc_flags` out 8: header byte 13, CWR..FIN, with FIN at bit 0.
- `desc_window` out 16: window.
- `desc_pl_len` out 16: number of payload bytes forwarded, saturating.
- `desc_err` out 1: runt segment, or data offset below 5.

## Operation
- A beat is transferred when `s_valid && s_ready`. Header bytes 0..19 are src port, dst port, seq, ack, offset/flags, window, checksum and urgent pointer.
- The checksum and urgent pointer are ignored. `doff` is the upper nibble of byte 12; the header length is 4·`doff`.
- States:
  - **HDR**: count bytes 0..19 and capture fields.
    - At byte 19 go to ERRD if `doff` < 5.
    - Otherwise go to DROP if dst ≠ `LOCAL_PORT`.
    - Otherwise go to OPT if `doff` > 5, else PAY.
    - If `s_last` arrives at byte 19 on a valid header, go to DESC with `pl_len` = 0.
    - `s_last` before byte 19 means `desc_err`=1, go to DESC.
  - **OPT**: discard bytes until the count reaches 4·`doff`, then go to PAY. If `s_last` arrives here, go to DESC with `pl_len` = 0 and `desc_err` = 1, because the option bytes are truncated.
  - **PAY**: pass bytes through combinationally.
    - `m_pl_data` = `s_data`.
    - `m_pl_valid` = `s_valid`.
    - `s_ready` = `m_pl_ready`.
    - `m_pl_last` = `s_last`.
    - Increment `pl_len` per beat, saturating at 0xFFFF.
    - Go to DESC on the `s_last` beat.
  - **ERRD**: discard to `s_last`, then go to DESC with `desc_err`=1.
  - **DROP**: discard to `s_last`, then return to HDR. No descriptor is emitted.
  - **DESC**: `desc_valid`=1 and `s_ready`=0. Fields are held stable. On `desc_ready`, return to HDR and clear counters.
- `s_ready`: 1 in HDR, OPT, ERRD and DROP; `m_pl_ready` in PAY; 0 in DESC and during `rst`.
- Descriptor fields reflect only the current segment. Fields not captured in a runt are 0.

## Timing
- Reset: state HDR. All counters are 0. `desc_*` = 0, `m_pl_valid` = 0, `m_pl_last` = 0.
- `desc_valid` rises the cycle after the `s_last` beat is accepted.
- DESC→HDR takes one cycle: the next segment's byte 0 can be accepted the cycle after `desc_valid && desc_ready`.
- Payload forwarding has zero latency. A stall on `m_pl_ready` stalls the input with no data loss.
- A zero-payload segment produces no payload beats.
- If `rst` is asserted mid-segment, the partial segment is discarded and no descriptor is emitted. Bytes of that segment still arriving after reset are parsed as a new header; the upstream framer must also be reset.
- `s_valid` gaps in any state hold the state and counters.

## Structure
- Shared package `tcp_pkg`:
  - constants `TCP_HDR_MIN_LEN`=20 and the flag bit positions (`FIN`=0, `SYN`=1, `RST`=2, `PSH`=3, `ACK`=4, `URG`=5, `ECE`=6, `CWR`=7);
  - the parser state encoding;
  - the packed `tcp_seg_desc_t` descriptor type, reused by `tcp_server`.
- No sub-module: one state machine, a 6-bit header/option byte counter, a 16-bit payload counter and field capture registers.

## Test plan
- SYN to port 80: seq=0x11223344, flags=0x02, `doff`=5, no payload → one descriptor with flags=0x02, seq=0x11223344, `pl_len`=0, `err`=0, no payload beats.
- ACK|PSH with `doff`=8 (12 option bytes) and 5 payload bytes A0..A4, with `m_pl_ready` toggling → payload A0..A4 in order, `m_pl_last` on A4, `pl_len`=5.
- dst port 0x0017 → no descriptor and no payload; the following valid segment parses correctly.
- `s_last` at byte 10 → descriptor with `err`=1 and `pl_len`=0; `doff`=3 → `err`=1 after draining to `s_last`.
- `desc_ready` held low 10 cycles → `s_ready`=0 and descriptor stable throughout; back-to-back segments accepted one cycle after the handshake.
- `rst` pulsed during PAY → outputs are zero the next cycle and the next full segment parses correctly.
